// File: rtl/chess_board_mem_if.sv
// Host/move-engine bus of the chess board-state memory.
// The master is the host side; the slave is the board memory.
interface chess_board_mem_if #(
    parameter int unsigned PIECE_W = 5
) ();
    localparam int unsigned SQ_W  = 6;
    localparam int unsigned CNT_W = 7;

    logic [SQ_W-1:0]    rd_addr;
    logic [PIECE_W-1:0] rd_data;
    logic               wr_en;
    logic [SQ_W-1:0]    wr_addr;
    logic [PIECE_W-1:0] wr_data;
    logic               move_valid;
    logic               move_ready;
    logic [SQ_W-1:0]    move_src;
    logic [SQ_W-1:0]    move_dst;
    logic               move_done;
    logic               move_err;
    logic [PIECE_W-1:0] captured;
    logic [CNT_W-1:0]   piece_count;
    logic               init_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, move_valid, move_src, move_dst,
        input  rd_data, move_ready, move_done, move_err, captured, piece_count, init_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, move_valid, move_src, move_dst,
        output rd_data, move_ready, move_done, move_err, captured, piece_count, init_busy
    );
endinterface

// File: rtl/chess_board_mem.sv
// 64-square board-state memory: self-initialising sweep, registered host read,
// host write port, atomic two-cycle move engine and live piece count.
module chess_board_mem #(
    parameter int unsigned PIECE_W   = 5,
    parameter int unsigned INIT_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    chess_board_mem_if.slave bus
);
    localparam int unsigned SQ_W   = 6;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned NUM_SQ = 64;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_MOVE
    } state_t;

    // Layout code of a square after reset (square = rank*8 + file).
    function automatic logic [PIECE_W-1:0] layout_code(input logic [SQ_W-1:0] sq);
        logic [3:0] back;
        logic [3:0] code;
        code = 4'd0;
        case (sq[2:0])
            3'd0, 3'd7: back = 4'd4;
            3'd1, 3'd6: back = 4'd2;
            3'd2, 3'd5: back = 4'd3;
            3'd3:       back = 4'd5;
            default:    back = 4'd6;
        endcase
        if (INIT_MODE == 0) begin
            case (sq[5:3])
                3'd0:    code = back;
                3'd1:    code = 4'd1;
                3'd6:    code = 4'd9;
                3'd7:    code = back + 4'd8;
                default: code = 4'd0;
            endcase
        end
        return PIECE_W'(code);
    endfunction

    logic [PIECE_W-1:0] mem [NUM_SQ];

    state_t             state, state_next;
    logic [SQ_W-1:0]    k;
    logic [SQ_W-1:0]    src_q, dst_q;
    logic               init_wr, host_wr, accept, move_fin, commit, move_rej;
    logic [PIECE_W-1:0] src_code, dst_code, wr_old, init_code;
    logic [CNT_W-1:0]   pc_next;

    always_comb begin
        src_code  = mem[src_q];
        dst_code  = mem[dst_q];
        wr_old    = mem[bus.wr_addr];
        init_code = layout_code(k);
        move_rej  = (src_q == dst_q) || (src_code == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle strobes; a committed move beats a colliding host write.
    always_comb begin
        state_next = state;
        init_wr    = 1'b0;
        accept     = 1'b0;
        move_fin   = 1'b0;
        commit     = 1'b0;
        host_wr    = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr = 1'b1;
                if (k == SQ_W'(NUM_SQ - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.move_valid) begin
                    accept     = 1'b1;
                    state_next = ST_MOVE;
                end
            end
            ST_MOVE: begin
                move_fin   = 1'b1;
                commit     = !move_rej;
                state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
        host_wr = bus.wr_en && (state != ST_INIT);
        if (commit && ((bus.wr_addr == src_q) || (bus.wr_addr == dst_q))) begin
            host_wr = 1'b0;
        end
    end

    // Piece count folds in the sweep, host write and capture deltas of this cycle.
    always_comb begin
        pc_next = bus.piece_count;
        if (init_wr && (init_code != '0)) begin
            pc_next = pc_next + CNT_W'(1);
        end
        if (host_wr && (wr_old == '0) && (bus.wr_data != '0)) begin
            pc_next = pc_next + CNT_W'(1);
        end
        if (host_wr && (wr_old != '0) && (bus.wr_data == '0)) begin
            pc_next = pc_next - CNT_W'(1);
        end
        if (commit && (dst_code != '0)) begin
            pc_next = pc_next - CNT_W'(1);
        end
    end

    // Board storage; later writes in this block take priority.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr) begin
                mem[k] <= init_code;
            end
            if (host_wr) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
            if (commit) begin
                mem[dst_q] <= src_code;
                mem[src_q] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k               <= '0;
            src_q           <= '0;
            dst_q           <= '0;
            bus.rd_data     <= '0;
            bus.move_ready  <= 1'b0;
            bus.move_done   <= 1'b0;
            bus.move_err    <= 1'b0;
            bus.captured    <= '0;
            bus.piece_count <= '0;
            bus.init_busy   <= 1'b1;
        end else begin
            if (init_wr) begin
                k <= k + SQ_W'(1);
            end
            if (accept) begin
                src_q <= bus.move_src;
                dst_q <= bus.move_dst;
            end
            bus.rd_data     <= (state == ST_INIT) ? '0 : mem[bus.rd_addr];
            bus.move_ready  <= (state_next == ST_IDLE);
            bus.init_busy   <= (state_next == ST_INIT);
            bus.move_done   <= move_fin;
            bus.piece_count <= pc_next;
            if (move_fin) begin
                bus.move_err <= move_rej;
                bus.captured <= move_rej ? '0 : dst_code;
            end
        end
    end
endmodule

// File: tb/tb_chess_board_mem.sv
// Randomised bench for chess_board_mem against an array model of the board.
module tb_chess_board_mem;
    localparam int unsigned PW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    chess_board_mem_if #(.PIECE_W(PW)) bus ();

    chess_board_mem #(.PIECE_W(PW), .INIT_MODE(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int model_mem [64];
    int back_rank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int start_code(input int sq);
        int r;
        int f;
        r = sq / 8;
        f = sq % 8;
        if (r == 0) return back_rank[f];
        if (r == 1) return 1;
        if (r == 6) return 9;
        if (r == 7) return back_rank[f] + 8;
        return 0;
    endfunction

    function automatic int model_count();
        int c;
        c = 0;
        foreach (model_mem[i]) if (model_mem[i] != 0) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sweep check: count grows square by square in order 0..63.
    task automatic init_sweep();
        int exp_pc;
        exp_pc = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (start_code(k) != 0) exp_pc++;
            check_eq($sformatf("init_pc_k%0d", k), 32'(bus.piece_count), 32'(exp_pc));
            check_eq("init_busy", 32'(bus.init_busy), (k < 63) ? 1 : 0);
            check_eq("init_ready", 32'(bus.move_ready), (k == 63) ? 1 : 0);
            check_eq("init_done", 32'(bus.move_done), 0);
            check_eq("init_rd", 32'(bus.rd_data), 0);
        end
        foreach (model_mem[i]) model_mem[i] = start_code(i);
    endtask

    task automatic read_check(input int sq, input string tag);
        bus.rd_addr = 6'(sq);
        step();
        check_eq($sformatf("%s_sq%0d", tag, sq), 32'(bus.rd_data), 32'(model_mem[sq]));
    endtask

    task automatic scan_board(input string tag);
        for (int sq = 0; sq < 64; sq++) read_check(sq, tag);
        check_eq({tag, "_pc"}, 32'(bus.piece_count), 32'(model_count()));
    endtask

    task automatic host_write(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 6'(a);
        bus.wr_data = PW'(d);
        step();
        bus.wr_en = 1'b0;
        model_mem[a] = d;
        check_eq("wr_pc", 32'(bus.piece_count), 32'(model_count()));
    endtask

    // One move, optionally with a host write at acceptance and/or in the move cycle.
    task automatic do_move(input int src, input int dst,
                           input bit wr_acc, input int wa, input int wad,
                           input bit wr_mv, input int wm, input int wmd);
        int  waited;
        int  old_src;
        int  old_dst;
        bit  rej;
        int  exp_cap;
        waited = 0;
        while (bus.move_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check_eq("mv_ready_wait", 32'(bus.move_ready), 1);
        if (bus.move_ready !== 1'b1) return;
        bus.move_valid = 1'b1;
        bus.move_src   = 6'(src);
        bus.move_dst   = 6'(dst);
        bus.wr_en      = wr_acc;
        bus.wr_addr    = 6'(wa);
        bus.wr_data    = PW'(wad);
        step();
        bus.move_valid = 1'b0;
        bus.wr_en      = 1'b0;
        if (wr_acc) model_mem[wa] = wad;
        check_eq("mv_done_early", 32'(bus.move_done), 0);
        check_eq("mv_ready_busy", 32'(bus.move_ready), 0);
        if (wr_mv) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 6'(wm);
            bus.wr_data = PW'(wmd);
        end
        old_src = model_mem[src];
        old_dst = model_mem[dst];
        rej     = (src == dst) || (old_src == 0);
        exp_cap = rej ? 0 : old_dst;
        step();
        bus.wr_en = 1'b0;
        if (!rej) begin
            model_mem[dst] = old_src;
            model_mem[src] = 0;
        end
        if (wr_mv && (rej || (wm != src && wm != dst))) model_mem[wm] = wmd;
        check_eq("mv_done", 32'(bus.move_done), 1);
        check_eq("mv_err", 32'(bus.move_err), 32'(rej));
        check_eq("mv_captured", 32'(bus.captured), 32'(exp_cap));
        check_eq("mv_pc", 32'(bus.piece_count), 32'(model_count()));
        step();
        check_eq("mv_done_pulse", 32'(bus.move_done), 0);
        check_eq("mv_err_hold", 32'(bus.move_err), 32'(rej));
        check_eq("mv_cap_hold", 32'(bus.captured), 32'(exp_cap));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int src;
        int dst;
        int wa;
        int wm;
        int tries;
        bit wr_acc;
        bit wr_mv;

        reset          = 1'b1;
        bus.rd_addr    = '0;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.move_valid = 1'b0;
        bus.move_src   = '0;
        bus.move_dst   = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_rd", 32'(bus.rd_data), 0);
            check_eq("rst_ready", 32'(bus.move_ready), 0);
            check_eq("rst_done", 32'(bus.move_done), 0);
            check_eq("rst_err", 32'(bus.move_err), 0);
            check_eq("rst_cap", 32'(bus.captured), 0);
            check_eq("rst_pc", 32'(bus.piece_count), 0);
            check_eq("rst_busy", 32'(bus.init_busy), 1);
        end
        reset = 1'b0;
        init_sweep();

        foreach (model_mem[i]) model_mem[i] = 0;
        model_mem[0] = 4;  model_mem[4] = 6;  model_mem[8] = 1;  model_mem[52] = 9;
        model_mem[59] = 13; model_mem[60] = 14; model_mem[20] = 0;
        read_check(0, "start");  read_check(4, "start");  read_check(8, "start");
        read_check(52, "start"); read_check(59, "start"); read_check(60, "start");
        read_check(20, "start");
        foreach (model_mem[i]) model_mem[i] = start_code(i);
        check_eq("start_pc", 32'(bus.piece_count), 32);
        check_eq("start_ready", 32'(bus.move_ready), 1);
        scan_board("start");

        // e2-e4, then a capture onto a host-placed black pawn.
        do_move(12, 28, 0, 0, 0, 0, 0, 0);
        read_check(28, "e4"); read_check(12, "e4");
        host_write(35, 9);
        check_eq("pc_33", 32'(bus.piece_count), 33);
        do_move(28, 35, 0, 0, 0, 0, 0, 0);
        check_eq("cap_9", 32'(bus.captured), 9);
        check_eq("pc_32", 32'(bus.piece_count), 32);
        read_check(35, "cap"); read_check(28, "cap");

        // Rejections leave the board alone.
        do_move(20, 30, 0, 0, 0, 0, 0, 0);
        do_move(0, 0, 0, 0, 0, 0, 0, 0);
        scan_board("rej");

        // Write committed ahead of the move accepted in the same cycle.
        do_move(40, 41, 1, 40, 3, 0, 0, 0);
        check_eq("wr_acc_err", 32'(bus.move_err), 0);
        check_eq("wr_acc_pc", 32'(bus.piece_count), 33);
        read_check(41, "wracc"); read_check(40, "wracc");

        // Move-cycle writes: colliding one loses, independent one lands.
        do_move(41, 42, 0, 0, 0, 1, 42, 5);
        read_check(42, "wrmv");
        do_move(42, 43, 0, 0, 0, 1, 20, 2);
        read_check(20, "wrmv"); read_check(43, "wrmv");
        check_eq("wrmv_pc", 32'(bus.piece_count), 32'(model_count()));

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: host_write(int'($urandom_range(0, 63)),
                              ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 14)));
                1: read_check(int'($urandom_range(0, 63)), "rnd");
                default: begin
                    src = int'($urandom_range(0, 63));
                    tries = 0;
                    while ($urandom_range(0, 1) == 1 && model_mem[src] == 0 && tries < 64) begin
                        src = int'($urandom_range(0, 63));
                        tries++;
                    end
                    dst    = int'($urandom_range(0, 63));
                    wr_acc = ($urandom_range(0, 3) == 0);
                    wr_mv  = ($urandom_range(0, 3) == 0);
                    wa     = int'($urandom_range(0, 63));
                    wm     = int'($urandom_range(0, 63));
                    while (wm == src || wm == dst) wm = int'($urandom_range(0, 63));
                    do_move(src, dst, wr_acc, wa, int'($urandom_range(0, 14)),
                            wr_mv, wm, int'($urandom_range(0, 14)));
                end
            endcase
        end
        scan_board("rnd");

        // Reset during the MOVE cycle aborts the move and re-runs the sweep.
        while (bus.move_ready !== 1'b1) step();
        bus.move_valid = 1'b1;
        bus.move_src   = 6'd1;
        bus.move_dst   = 6'd18;
        step();
        bus.move_valid = 1'b0;
        reset = 1'b1;
        step();
        check_eq("abort_done", 32'(bus.move_done), 0);
        check_eq("abort_busy", 32'(bus.init_busy), 1);
        check_eq("abort_pc", 32'(bus.piece_count), 0);
        step();
        check_eq("abort_done2", 32'(bus.move_done), 0);
        reset = 1'b0;
        init_sweep();
        scan_board("rerun");
        check_eq("rerun_pc", 32'(bus.piece_count), 32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
